// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned N x N multiplier with per-transaction exact / approximate (truncated, OR-compressed low rows) mode.
// Latency: PIPE cycles from input handshake to out_valid; one transaction per cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid | out_ready; every stage (bubbles included) holds while stalled.
// Optional macro APPROX_MUL_COMP_EN adds a 2^(L-1) rounding bias to approximate results.
module approx_mul_pipe #(
  parameter int N     = 8,
  parameter int L     = 6,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   z,
  output logic             out_approx,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int W = 2 * N;

  // Columns at or above L survive truncation.
  localparam logic [W-1:0] KEEP = {W{1'b1}} << L;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef APPROX_MUL_COMP_EN
  // 2^(L-1), collapsing to zero when L = 0.
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] BIAS = (ONE << L) >> 1;
`endif

  logic [W-1:0] x_w;
  logic [W-1:0] y_w;
  logic [W-1:0] x_hi;
  logic [W-1:0] exact_p;
  logic [W-1:0] upper;
  logic [W-1:0] pair_sum;
  logic [W-1:0] odd_row;
  logic [W-1:0] approx_p;
  logic [W-1:0] prod;
  logic [W-1:0] row_a;
  logic [W-1:0] row_b;
  logic [N-1:0] x_sh;

  logic         stg_vld [PIPE];
  logic [W-1:0] stg_z   [PIPE];
  logic         stg_apx [PIPE];

  assign x_w  = {{N{1'b0}}, x};
  assign y_w  = {{N{1'b0}}, y};

  // Rows at or above L are exact: y times the upper multiplier bits, realigned.
  assign x_hi    = x_w >> L;
  assign upper   = (y_w * x_hi) << L;
  assign exact_p = x_w * y_w;

  // Low rows are taken in pairs; each pair contributes the OR of its two rows, truncated below L.
  always_comb begin
    pair_sum = '0;
    row_a    = '0;
    row_b    = '0;
    x_sh     = '0;
    for (int k = 0; k < L / 2; k++) begin
      x_sh     = x >> (2 * k);
      row_a    = x_sh[0] ? (y_w << (2 * k))     : '0;
      row_b    = x_sh[1] ? (y_w << (2 * k + 1)) : '0;
      pair_sum = pair_sum + ((row_a | row_b) & KEEP);
    end
  end

  // With odd L the top low row has no partner and is added as-is (still truncated).
  if ((L % 2) == 1) begin : g_odd
    assign odd_row = x[L-1] ? ((y_w << (L - 1)) & KEEP) : '0;
  end else begin : g_even
    assign odd_row = '0;
  end

`ifdef APPROX_MUL_COMP_EN
  assign approx_p = upper + pair_sum + odd_row + BIAS;
`else
  assign approx_p = upper + pair_sum + odd_row;
`endif

  assign prod = approx_en ? approx_p : exact_p;

  // Stall whenever a held result is not being taken.
  assign in_ready   = !out_valid | out_ready;
  assign out_valid  = stg_vld[PIPE-1];
  assign z          = stg_z[PIPE-1];
  assign out_approx = stg_apx[PIPE-1];

  // First stage captures the finished product and its mode; a bubble when in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld[0] <= 1'b0;
      stg_z[0]   <= '0;
      stg_apx[0] <= 1'b0;
    end else if (in_ready) begin
      stg_vld[0] <= in_valid;
      stg_z[0]   <= prod;
      stg_apx[0] <= approx_en;
    end
  end

  for (genvar g = 1; g < PIPE; g++) begin : g_stage
    // Later stages shift forward together with the first one on every unstalled cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_vld[g] <= 1'b0;
        stg_z[g]   <= '0;
        stg_apx[g] <= 1'b0;
      end else if (in_ready) begin
        stg_vld[g] <= stg_vld[g-1];
        stg_z[g]   <= stg_z[g-1];
        stg_apx[g] <= stg_apx[g-1];
      end
    end
  end

  // Count delivered approximate results, sticking at the top value.
  always_ff @(posedge clk) begin
    if (rst) begin
      approx_cnt <= '0;
    end else if (out_valid && out_ready && out_approx && (approx_cnt != CNT_MAX)) begin
      approx_cnt <= approx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (N=8, L=6, PIPE=2, CNT_W=2).
// Reference model computes products from partial-product rows; a negedge monitor scoreboards every handshake.
// Directed tests pin latency, literal products, stall stability, reset flush and counter saturation.
module tb_approx_mul_pipe;

  localparam int N     = 8;
  localparam int L     = 6;
  localparam int PIPE  = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef APPROX_MUL_COMP_EN
  localparam int BIAS = 32;
`else
  localparam int BIAS = 0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   z;
  logic             out_approx;
  logic [CNT_W-1:0] approx_cnt;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  int mcnt   = 0;
  logic [2*N:0] q[$];

  approx_mul_pipe #(.N(N), .L(L), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .out_approx(out_approx), .approx_cnt(approx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int ppb(input logic [N-1:0] a, input logic [N-1:0] b, input int i, input int j);
    if (j < 0 || j >= N) return 0;
    return int'(a[i] & b[j]);
  endfunction

  // Product straight from the partial-product description.
  function automatic logic [2*N-1:0] model_z(input logic [N-1:0] a, input logic [N-1:0] b, input bit ap);
    int r;
    if (!ap) return 16'(int'(a) * int'(b));
    r = 0;
    for (int i = L; i < N; i++)
      if (a[i]) r += int'(b) << i;
    for (int k = 0; k < L / 2; k++)
      for (int c = L; c < 2 * N; c++)
        if ((ppb(a, b, 2 * k, c - 2 * k) | ppb(a, b, 2 * k + 1, c - 2 * k - 1)) != 0)
          r += 1 << c;
    if ((L % 2) == 1)
      for (int c = L; c < 2 * N; c++)
        if (ppb(a, b, L - 1, c - L + 1) != 0) r += 1 << c;
    r += BIAS;
    return 16'(r);
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic           prev_stall = 1'b0;
  logic [2*N-1:0] prev_z;
  logic           prev_apx;
  always @(negedge clk) begin
    logic [2*N:0] e;
    if (rst) begin
      q.delete();
      mcnt       = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      check("approx_cnt", approx_cnt, mcnt);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_z", z, prev_z);
        check("stall_apx", out_approx, prev_apx);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("z", z, e[2*N-1:0]);
          check("out_approx", out_approx, e[2*N]);
          if (e[2*N] && mcnt < CMAX) mcnt++;
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        q.push_back({approx_en, model_z(x, y, approx_en)});
      end
      prev_stall = out_valid && !out_ready;
      prev_z     = z;
      prev_apx   = out_approx;
    end
  end

  // Present operands from just after a rising edge and hold until accepted.
  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input bit ap);
    int n;
    n = 0;
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    approx_en = ap;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // One transaction with literal expectations on latency, product, mode and counter.
  task automatic push_check(input logic [N-1:0] a, input logic [N-1:0] b, input bit ap,
                            input int exp_z, input int exp_cnt);
    align();
    push(a, b, ap);
    @(negedge clk);
    check("lat_early", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lit_z", z, exp_z);
    check("lit_apx", out_approx, ap);
    @(negedge clk);
    check("lit_cnt", approx_cnt, exp_cnt);
  endtask

  logic [N-1:0] sx [8] = '{8'd255, 8'd3, 8'd64, 8'd17, 8'd200, 8'd128, 8'd1, 8'd170};
  logic [N-1:0] sy [8] = '{8'd255, 8'd5, 8'd200, 8'd34, 8'd99, 8'd128, 8'd1, 8'd85};
  bit           sa [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int out0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    approx_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_out_approx", out_approx, 0);
    check("rst_cnt", approx_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    push_check(8'd255, 8'd255, 1'b0, 65025, 0);
    push_check(8'd255, 8'd255, 1'b1, 59520 + BIAS, 1);
    push_check(8'd3, 8'd5, 1'b1, 0 + BIAS, 2);
    push_check(8'd64, 8'd200, 1'b1, 12800 + BIAS, 3);

    // Back-to-back stream with a three-cycle output stall in the middle.
    out0 = n_out;
    align();
    fork
      begin
        for (int i = 0; i < 8; i++) push(sx[i], sy[i], sa[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("stream_drained", q.size(), 0);
    check("stream_count", n_out - out0, 8);

    // Reset with two transactions in flight; in_valid high during reset must be ignored.
    align();
    push(8'd10, 8'd20, 1'b1);
    push(8'd30, 8'd40, 1'b1);
    rst       = 1'b1;
    in_valid  = 1'b1;
    x         = 8'd99;
    y         = 8'd77;
    approx_en = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out0     = n_out;
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_cnt", approx_cnt, 0);
    check("flush_z", z, 0);
    repeat (6) @(negedge clk);
    check("flush_no_output", n_out - out0, 0);

    // Saturating counter: 1, 2, 3, 3, 3.
    for (int i = 0; i < 5; i++) begin
      align();
      push(8'(i + 7), 8'(3 * i + 11), 1'b1);
      repeat (3) @(negedge clk);
      check("sat_cnt", approx_cnt, (i < 3) ? i + 1 : 3);
    end

    repeat (2) @(negedge clk);
    check("final_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
